// File: rtl/selector_round_robin_arbiter.sv
// rtl/selector_round_robin_arbiter.sv - round-robin owner arbiter for a shared 4-way selector mux
module selector_round_robin_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  output logic [3:0] grant,
  output logic [1:0] selector,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [1:0] TURN_LIMIT = 2'(TURNAROUND);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] selector_q, selector_d;
  logic       busy_q, busy_d;
  logic [7:0] hold_count_q, hold_count_d;
  logic [1:0] pointer_q, pointer_d;
  logic [1:0] turn_count_q, turn_count_d;

  logic [3:0] owner_onehot;
  logic [3:0] others_pending;
  logic       owner_requesting;
  logic       hold_expired;
  logic       forced_release;
  logic       release_owner;
  logic       do_pick;
  logic [1:0] pick_ptr;
  logic [3:0] pick_mask;
  logic [2:0] pick_res;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Cyclic search from ptr; returns {found, index}. Scanning offsets high
  // to low lets the smallest offset from ptr overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  // Owner status: the selector always names the current owner while in GRANT.
  always_comb begin
    owner_onehot     = onehot(selector_q);
    others_pending   = request & ~owner_onehot;
    owner_requesting = |(request & owner_onehot);
    hold_expired     = (hold_count_q >= HOLD_LIMIT);
    forced_release   = owner_requesting && hold_expired && (others_pending != 4'b0000);
    release_owner    = !owner_requesting || forced_release;
  end

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    selector_d   = selector_q;
    busy_d       = busy_q;
    hold_count_d = hold_count_q;
    pointer_d    = pointer_q;
    turn_count_d = turn_count_q;
    do_pick      = 1'b0;
    pick_ptr     = pointer_q;
    pick_mask    = request;

    case (state_q)
      ST_IDLE: begin
        do_pick = 1'b1;
      end

      ST_GRANT: begin
        if (release_owner) begin
          grant_d   = 4'b0000;
          pointer_d = selector_q + 2'd1;
          if (TURN_LIMIT != 2'd0) begin
            state_d      = ST_TURN;
            turn_count_d = 2'd1;
          end else begin
            // No dead time: hand over on this same edge, skipping the
            // outgoing owner only when it was pushed out by the hold limit.
            do_pick   = 1'b1;
            pick_ptr  = selector_q + 2'd1;
            pick_mask = forced_release ? others_pending : request;
          end
        end else if (!hold_expired) begin
          hold_count_d = hold_count_q + 8'd1;
        end
      end

      ST_TURN: begin
        if (turn_count_q == TURN_LIMIT) begin
          do_pick = 1'b1;
        end else begin
          turn_count_d = turn_count_q + 2'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase

    pick_res = rr_pick(pick_ptr, pick_mask);
    if (do_pick) begin
      if (pick_res[2]) begin
        state_d      = ST_GRANT;
        grant_d      = onehot(pick_res[1:0]);
        selector_d   = pick_res[1:0];
        busy_d       = 1'b1;
        hold_count_d = 8'd1;
      end else begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    end
  end

  // State register with synchronous reset; reset drops any grant at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 4'b0000;
      selector_q   <= 2'b00;
      busy_q       <= 1'b0;
      hold_count_q <= 8'd0;
      pointer_q    <= 2'd0;
      turn_count_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      selector_q   <= selector_d;
      busy_q       <= busy_d;
      hold_count_q <= hold_count_d;
      pointer_q    <= pointer_d;
      turn_count_q <= turn_count_d;
    end
  end

  assign grant    = grant_q;
  assign selector = selector_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_selector_round_robin_arbiter.sv
// tb/tb_selector_round_robin_arbiter.sv - self-checking bench for selector_round_robin_arbiter
module tb_selector_round_robin_arbiter;

  localparam int MAXH = 8;

  logic       clk;
  logic       reset;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] selector_a, selector_b;
  logic       busy_a, busy_b;
  logic       check_en;

  int checks;
  int passed;

  // Reference model state per instance (0: turnaround 1, 1: turnaround 0).
  int m_owner[2];
  int m_gap[2];
  int m_hold[2];
  int m_ptr[2];
  int m_sel[2];
  int m_busy[2];

  selector_round_robin_arbiter #(.MAX_HOLD(MAXH), .TURNAROUND(1)) dut_a (
    .clk(clk), .reset(reset), .request(req_a),
    .grant(grant_a), .selector(selector_a), .busy(busy_a)
  );

  selector_round_robin_arbiter #(.MAX_HOLD(MAXH), .TURNAROUND(0)) dut_b (
    .clk(clk), .reset(reset), .request(req_b),
    .grant(grant_b), .selector(selector_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input int ptr, input logic [3:0] req);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (ptr + i) % 4;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic start_owner(input int m, input int w);
    if (w >= 0) begin
      m_owner[m] = w;
      m_sel[m]   = w;
      m_hold[m]  = 1;
      m_busy[m]  = 1;
    end else begin
      m_owner[m] = -1;
      m_busy[m]  = 0;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] req, input logic rst, input int turn);
    logic [3:0] others;
    bit forced;
    if (rst) begin
      m_owner[m] = -1; m_gap[m] = 0; m_hold[m] = 0;
      m_ptr[m] = 0; m_sel[m] = 0; m_busy[m] = 0;
    end else if (m_owner[m] >= 0) begin
      others = req & ~(4'b0001 << m_owner[m]);
      forced = req[m_owner[m]] && (m_hold[m] >= MAXH) && (others != 0);
      if (req[m_owner[m]] && !forced) begin
        if (m_hold[m] < MAXH) m_hold[m]++;
      end else begin
        m_ptr[m] = (m_owner[m] + 1) % 4;
        m_owner[m] = -1;
        if (turn > 0) m_gap[m] = 1;
        else start_owner(m, pick(m_ptr[m], forced ? others : req));
      end
    end else if (m_gap[m] > 0) begin
      if (m_gap[m] == turn) begin
        m_gap[m] = 0;
        start_owner(m, pick(m_ptr[m], req));
      end else begin
        m_gap[m]++;
      end
    end else begin
      start_owner(m, pick(m_ptr[m], req));
    end
  endtask

  function automatic int exp_grant(input int m);
    return (m_owner[m] >= 0) ? (1 << m_owner[m]) : 0;
  endfunction

  // Advance the model on the same edge the DUTs sample.
  always @(posedge clk) begin
    model_step(0, req_a, reset, 1);
    model_step(1, req_b, reset, 0);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_a_grant", int'(grant_a), exp_grant(0));
      chk("model_a_selector", int'(selector_a), m_sel[0]);
      chk("model_a_busy", int'(busy_a), m_busy[0]);
      chk("model_b_grant", int'(grant_b), exp_grant(1));
      chk("model_b_selector", int'(selector_b), m_sel[1]);
      chk("model_b_busy", int'(busy_b), m_busy[1]);
      chk("onehot_a", int'($countones(grant_a) <= 1), 1);
      chk("onehot_b", int'($countones(grant_b) <= 1), 1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic lit_a(input string name, input int g, input int s, input int b);
    chk({name, "_grant"}, int'(grant_a), g);
    chk({name, "_selector"}, int'(selector_a), s);
    chk({name, "_busy"}, int'(busy_a), b);
  endtask

  task automatic lit_b(input string name, input int g, input int s, input int b);
    chk({name, "_grant"}, int'(grant_b), g);
    chk({name, "_selector"}, int'(selector_b), s);
    chk({name, "_busy"}, int'(busy_b), b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; passed = 0; check_en = 1'b0;
    reset = 1'b1; req_a = 4'b0000; req_b = 4'b0000;
    tick();
    tick();
    check_en = 1'b1;
    reset = 1'b0;
    lit_a("reset_a", 0, 0, 0);
    lit_b("reset_b", 0, 0, 0);

    // Single requester held: never preempted, then one turnaround cycle.
    req_a = 4'b0100;
    tick();
    lit_a("single_first", 4'b0100, 2, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("single_hold", int'(grant_a), 4'b0100);
    end
    req_a = 4'b0000;
    tick();
    lit_a("single_drop", 0, 2, 1);
    tick();
    lit_a("single_idle", 0, 2, 0);

    // All four requesting: rotation with 8-cycle slots and one gap cycle.
    do_reset();
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < MAXH; c++) begin
        tick();
        chk("rr_grant", int'(grant_a), 1 << (i % 4));
        chk("rr_selector", int'(selector_a), i % 4);
      end
      if (i < 4) begin
        tick();
        lit_a("rr_gap", 0, i % 4, 1);
      end
    end

    // Owner 3 releases with 0011 pending: pointer wraps to 0.
    do_reset();
    req_a = 4'b1000;
    tick();
    lit_a("wrap_own3", 4'b1000, 3, 1);
    req_a = 4'b0011;
    tick();
    lit_a("wrap_gap", 0, 3, 1);
    tick();
    lit_a("wrap_new", 4'b0001, 0, 1);

    // Reset during a grant drops it immediately and clears the pointer.
    do_reset();
    req_a = 4'b0010;
    tick();
    lit_a("rst_own1", 4'b0010, 1, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    lit_a("rst_mid", 0, 0, 0);
    reset = 1'b0;
    req_a = 4'b0110;
    tick();
    lit_a("rst_after", 4'b0010, 1, 1);

    // Request 2 present only while the turnaround is pending: never granted.
    do_reset();
    req_a = 4'b0001;
    tick();
    lit_a("pulse_own0", 4'b0001, 0, 1);
    req_a = 4'b0100;
    tick();
    lit_a("pulse_gap", 0, 0, 1);
    req_a = 4'b0000;
    tick();
    lit_a("pulse_idle", 0, 0, 0);
    tick();
    lit_a("pulse_idle2", 0, 0, 0);

    // Zero turnaround: immediate handover, and forced release skips the owner.
    do_reset();
    req_b = 4'b0001;
    tick();
    lit_b("t0_own0", 4'b0001, 0, 1);
    tick();
    lit_b("t0_hold0", 4'b0001, 0, 1);
    req_b = 4'b0100;
    tick();
    lit_b("t0_swap", 4'b0100, 2, 1);
    req_b = 4'b0101;
    for (int i = 0; i < MAXH - 1; i++) begin
      tick();
      chk("t0_hold2", int'(grant_b), 4'b0100);
    end
    tick();
    lit_b("t0_forced", 4'b0001, 0, 1);
    req_b = 4'b0000;
    tick();
    lit_b("t0_idle", 0, 0, 0);

    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
